// File: rtl/alu_share_arbiter_if.sv
// Client/ALU-facing signal bundle for alu_share_arbiter.
// err exists only when ALU_ARB_OPCHECK_EN is defined.
interface alu_share_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 4
);
  logic [N_REQ-1:0]        req;
  logic [3*N_REQ-1:0]      req_opcode;
  logic [DATA_W*N_REQ-1:0] req_data_a;
  logic [DATA_W*N_REQ-1:0] req_data_b;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       result;
  logic                    busy;
  logic [2:0]              alu_opcode;
  logic [DATA_W-1:0]       alu_data_a;
  logic [DATA_W-1:0]       alu_data_b;
  logic                    alu_enable;
  logic [DATA_W-1:0]       alu_bus;
`ifdef ALU_ARB_OPCHECK_EN
  logic                    err;

  modport master (
    input  req, req_opcode, req_data_a, req_data_b, alu_bus,
    output ack, result, busy, alu_opcode, alu_data_a, alu_data_b, alu_enable, err
  );
  modport slave (
    output req, req_opcode, req_data_a, req_data_b, alu_bus,
    input  ack, result, busy, alu_opcode, alu_data_a, alu_data_b, alu_enable, err
  );
`else
  modport master (
    input  req, req_opcode, req_data_a, req_data_b, alu_bus,
    output ack, result, busy, alu_opcode, alu_data_a, alu_data_b, alu_enable
  );
  modport slave (
    output req, req_opcode, req_data_a, req_data_b, alu_bus,
    input  ack, result, busy, alu_opcode, alu_data_a, alu_data_b, alu_enable
  );
`endif
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin scheduler sharing one tri-state ALU among N_REQ requesters.
// Optional ALU_ARB_OPCHECK_EN: illegal opcodes bypass the ALU and return 0 with err.
module alu_share_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CAPT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, ptr_q, ptr_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
`ifdef ALU_ARB_OPCHECK_EN
  logic              err_q, err_d;
  logic              op_legal;
`endif

  logic              found;
  logic [IDX_W-1:0]  sel, cand;
  logic [2:0]        op_sel;
  logic [DATA_W-1:0] a_sel, b_sel;

  // First pending requester at or after ptr_q, wrapping modulo N_REQ
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == sel) begin
        op_sel = bus.req_opcode[3*i +: 3];
        a_sel  = bus.req_data_a[DATA_W*i +: DATA_W];
        b_sel  = bus.req_data_b[DATA_W*i +: DATA_W];
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign op_legal = (op_sel == 3'b001) || (op_sel == 3'b010) || (op_sel == 3'b110);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ack_d   = '0;
`ifdef ALU_ARB_OPCHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d = sel;
`ifdef ALU_ARB_OPCHECK_EN
          if (op_legal) begin
            op_d    = op_sel;
            a_d     = a_sel;
            b_d     = b_sel;
            state_d = DRIVE;
          end else begin
            // Rejected op never reaches the ALU; complete immediately with 0
            res_d   = '0;
            ack_d   = N_REQ'(1) << sel;
            err_d   = 1'b1;
            state_d = CAPT;
          end
`else
          op_d    = op_sel;
          a_d     = a_sel;
          b_d     = b_sel;
          state_d = DRIVE;
`endif
        end
      end
      DRIVE: begin
        res_d   = bus.alu_bus;
        ack_d   = N_REQ'(1) << idx_q;
        state_d = CAPT;
      end
      CAPT: begin
        ptr_d   = IDX_W'((32'(idx_q) + 32'd1) % N_REQ);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      ptr_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      ack_q <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      ack_q <= ack_d;
`ifdef ALU_ARB_OPCHECK_EN
      err_q <= err_d;
`endif
    end
  end

  // Enable decoded from registered state so reset releases the bus at once
  assign bus.alu_enable = (state_q == DRIVE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.alu_opcode = op_q;
  assign bus.alu_data_a = a_q;
  assign bus.alu_data_b = b_q;
  assign bus.result     = res_q;
  assign bus.ack        = ack_q;
`ifdef ALU_ARB_OPCHECK_EN
  assign bus.err        = err_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scoreboard bench for alu_share_arbiter with a behavioural ALU model.
// Define ALU_ARB_OPCHECK_EN to exercise the opcode-check variant.
module tb_alu_share_arbiter;
  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   en_count = 0;
  logic prev_en  = 1'b0;
  int   cyc;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  alu_share_arbiter_if #(.N_REQ(4), .DATA_W(4)) ifc ();

  alu_share_arbiter #(.N_REQ(4), .DATA_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b110:  return ~b;
      default: return 4'b0000;
    endcase
  endfunction

  // Shared ALU: drives the bus only while enabled, otherwise released low
  assign ifc.alu_bus = ifc.alu_enable ? alu_f(ifc.alu_opcode, ifc.alu_data_a, ifc.alu_data_b) : 4'b0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void push(input int idx, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t x;
    x.ack = 4'(1 << idx);
    x.res = alu_f(op, a, b);
`ifdef ALU_ARB_OPCHECK_EN
    x.err = !((op == 3'b001) || (op == 3'b010) || (op == 3'b110));
`else
    x.err = 1'b0;
`endif
    sb.push_back(x);
  endfunction

  task automatic set_slice(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    ifc.req_opcode[3*i +: 3] = op;
    ifc.req_data_a[4*i +: 4] = a;
    ifc.req_data_b[4*i +: 4] = b;
  endtask

  task automatic wait_ack(input string tag, output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (ifc.ack != 4'b0000) break;
    end
    if (ifc.ack == 4'b0000) chk({tag, "_timeout"}, 32'(ifc.ack), 1);
  endtask

  // Scoreboard and bus-turnaround monitor
  always @(negedge clk) begin
    if (ifc.alu_enable) begin
      en_count++;
      chk("enable_gap", 32'(prev_en), 0);
    end
    prev_en = ifc.alu_enable;
    if (ifc.ack != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'(ifc.ack), 0);
      end else begin
        e = sb.pop_front();
        chk("ack_onehot", 32'(ifc.ack), 32'(e.ack));
        chk("result", 32'(ifc.result), 32'(e.res));
        chk("enable_in_ack", 32'(ifc.alu_enable), 0);
`ifdef ALU_ARB_OPCHECK_EN
        chk("err", 32'(ifc.err), 32'(e.err));
`endif
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    ifc.req        = '0;
    ifc.req_opcode = '0;
    ifc.req_data_a = '0;
    ifc.req_data_b = '0;

    // Reset values
    @(negedge clk);
    chk("rst_ack", 32'(ifc.ack), 0);
    chk("rst_result", 32'(ifc.result), 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_enable", 32'(ifc.alu_enable), 0);
    chk("rst_opcode", 32'(ifc.alu_opcode), 0);
    chk("rst_data_a", 32'(ifc.alu_data_a), 0);
    chk("rst_data_b", 32'(ifc.alu_data_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single OR request
    @(negedge clk);
    en_count = 0;
    set_slice(0, 3'b001, 4'b1010, 4'b0101);
    ifc.req = 4'b0001;
    push(0, 3'b001, 4'b1010, 4'b0101);
    @(negedge clk);
    chk("t1_enable", 32'(ifc.alu_enable), 1);
    chk("t1_busy", 32'(ifc.busy), 1);
    chk("t1_no_ack_yet", 32'(ifc.ack), 0);
    chk("t1_opcode", 32'(ifc.alu_opcode), 1);
    chk("t1_data_a", 32'(ifc.alu_data_a), 'ha);
    chk("t1_data_b", 32'(ifc.alu_data_b), 'h5);
    @(negedge clk);
    chk("t1_ack", 32'(ifc.ack), 1);
    chk("t1_enable_cycles", 32'(en_count), 1);
    ifc.req = 4'b0000;
    @(negedge clk);
    chk("t1_idle_busy", 32'(ifc.busy), 0);

    // Reset during DRIVE aborts requester 1 without ack
    @(negedge clk);
    set_slice(1, 3'b110, 4'b1010, 4'b0011);
    ifc.req = 4'b0010;
    @(negedge clk);
    chk("rst_pre_enable", 32'(ifc.alu_enable), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_enable", 32'(ifc.alu_enable), 0);
    chk("rst_async_busy", 32'(ifc.busy), 0);
    chk("rst_async_ack", 32'(ifc.ack), 0);
    chk("rst_async_opcode", 32'(ifc.alu_opcode), 0);

    // All four requesting continuously after reset release
    set_slice(0, 3'b010, 4'b0011, 4'b0101);
    set_slice(1, 3'b110, 4'b1010, 4'b0000);
    set_slice(2, 3'b001, 4'b1000, 4'b0001);
    set_slice(3, 3'b010, 4'b1111, 4'b1111);
    ifc.req = 4'b1111;
    push(0, 3'b010, 4'b0011, 4'b0101);
    push(1, 3'b110, 4'b1010, 4'b0000);
    push(2, 3'b001, 4'b1000, 4'b0001);
    push(3, 3'b010, 4'b1111, 4'b1111);
    push(0, 3'b010, 4'b0011, 4'b0101);
    @(negedge clk);
    chk("rst_hold_busy", 32'(ifc.busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_ack("rr", cyc);
      chk("rr_latency", 32'(cyc), (i == 0) ? 2 : 3);
    end
    ifc.req = 4'b0000;

    // Requester 0 drops req and changes A while in DRIVE
    @(negedge clk);
    set_slice(0, 3'b001, 4'b0100, 4'b0001);
    ifc.req = 4'b0001;
    push(0, 3'b001, 4'b0100, 4'b0001);
    @(negedge clk);
    chk("t3_enable", 32'(ifc.alu_enable), 1);
    ifc.req = 4'b0000;
    set_slice(0, 3'b001, 4'b1111, 4'b0001);
    wait_ack("t3", cyc);
    chk("t3_latency", 32'(cyc), 1);
    chk("t3_latched_a", 32'(ifc.alu_data_a), 'h4);

    // Serve requester 1 alone so the pointer lands on 2
    @(negedge clk);
    set_slice(1, 3'b110, 4'b0000, 4'b0101);
    ifc.req = 4'b0010;
    push(1, 3'b110, 4'b0000, 4'b0101);
    wait_ack("ptr2", cyc);
    chk("ptr2_latency", 32'(cyc), 2);
    ifc.req = 4'b0000;

    // req1 and req3 together with pointer at 2: req3 first
    @(negedge clk);
    set_slice(3, 3'b010, 4'b1100, 4'b1010);
    set_slice(1, 3'b001, 4'b0011, 4'b0100);
    ifc.req = 4'b1010;
    push(3, 3'b010, 4'b1100, 4'b1010);
    push(1, 3'b001, 4'b0011, 4'b0100);
    wait_ack("wrap3", cyc);
    chk("wrap_first", 32'(ifc.ack), 'h8);
    ifc.req = 4'b0010;
    wait_ack("wrap1", cyc);
    chk("wrap_second", 32'(ifc.ack), 'h2);
    chk("wrap_latency", 32'(cyc), 3);
    ifc.req = 4'b0000;

    // Undefined opcode 111
    @(negedge clk);
    en_count = 0;
    set_slice(0, 3'b111, 4'b1111, 4'b1111);
    ifc.req = 4'b0001;
    push(0, 3'b111, 4'b1111, 4'b1111);
    wait_ack("badop", cyc);
    chk("badop_result", 32'(ifc.result), 0);
`ifdef ALU_ARB_OPCHECK_EN
    chk("badop_latency", 32'(cyc), 1);
    chk("badop_enable_cycles", 32'(en_count), 0);
    chk("badop_err", 32'(ifc.err), 1);
`else
    chk("badop_latency", 32'(cyc), 2);
    chk("badop_enable_cycles", 32'(en_count), 1);
`endif
    ifc.req = 4'b0000;

    repeat (3) @(negedge clk);
    chk("final_busy", 32'(ifc.busy), 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
